zprize_mul_kara_stream: RTL and testbench
=========================================

ZPRIZE_MUL_KARA_STREAM -- requirements
Module: zprize_mul_kara_stream

Interface
REQ-001 SHALL have parameter W, default 384: operand width; must be even.
REQ-002 SHALL have parameter P, default 4: leaf-multiplier pipeline depth in cycles.
REQ-003 SHALL have parameter M, default 32: metadata sideband width.
REQ-004 SHALL have parameter D, default P+5: output FIFO depth; elaboration error if D < P+3.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-008 SHALL have ports in0 and in1, input, W each: unsigned operands.
REQ-009 SHALL have port m_i, input, M: metadata carried with the operands.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-011 SHALL have port out0, output, 2W: product in0*in1.
REQ-012 SHALL have port m_o, output, M: metadata of the product on out0.
REQ-013 SHALL have port chk_err, output, 1: sticky residue-check error flag.

Function
REQ-014 SHALL accept an operation when in_valid && in_ready are high on the same rising edge.
REQ-015 SHALL compute out0 = in0*in1 exactly using one Karatsuba level: split each operand into W/2 halves x1:x0 and y1:y0.
REQ-016 SHALL compute the three partial products: z0 = x0*y0, z2 = x1*y1 (W/2 x W/2), and m1 = (x0+x1)*(y0+y1) ((W/2+1) x (W/2+1), carries kept).
REQ-017 SHALL compute z1 = m1 - z2 - z0 in W+2 bits and form out0 = (z2<<W) + (z1<<W/2) + z0.
REQ-018 SHALL use a fixed pipeline latency of LAT = P+3 cycles from acceptance to FIFO write:
- 1 cycle pre-add;
- P cycles multiply;
- 1 cycle z1 subtract;
- 1 cycle final sum.
REQ-019 SHALL never stall the pipeline; the valid bit and m_i travel alongside the data in lockstep.
REQ-020 SHALL write each pipeline result into a D-entry FIFO; out_valid = FIFO not empty; pop on out_valid && out_ready.
REQ-021 SHALL keep a credit counter (reset value D) that decrements on accept, increments on pop, and is unchanged when both happen in one cycle.
REQ-022 SHALL drive in_ready = (credits != 0), so the FIFO can never overflow.
REQ-023 SHALL return results strictly in acceptance order; m_o always pairs with its own out0.
REQ-024 SHALL sustain one accept and one pop per cycle when out_ready is held high (full throughput, no bubbles).
REQ-025 SHALL hold out0 and m_o stable while out_valid && !out_ready.
REQ-026 SHALL wrap the FIFO pointers modulo D; D need not be a power of two.

Reset
REQ-027 SHALL on rst clear all pipeline valid bits, empty the FIFO, set credits = D, out_valid = 0 and chk_err = 0; out0 and m_o read 0.
REQ-028 SHALL discard every in-flight operation on a mid-operation reset; none of them appears after reset.
REQ-029 SHALL drive in_ready high in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL compile the residue self-check in when macro ZPRIZE_MUL_RESCHK_EN is defined:
- carry (in0 mod 3) and (in1 mod 3) down the pipeline;
- at FIFO write, compare (a*b mod 3) against (out0 mod 3);
- on mismatch set chk_err, which stays set until rst.
REQ-031 SHALL tie chk_err to constant 0 and add no residue logic when ZPRIZE_MUL_RESCHK_EN is undefined.

Structure
REQ-032 SHALL place the LAT formula, the D legality check and the half-width / WN = W/2+1 constants in the shared package zprize_mul_pkg.
REQ-033 SHALL implement the leaf multiplier as a single sub-module, zprize_mul_leaf_pipe (parameters: width, P, pass-through width), instantiated three times.
REQ-034 SHALL contain only the FIFO and credit logic in this top level, with no further hierarchy.

Verification
REQ-035 SHALL verify the all-ones case: W=16, in0=in1=0xFFFF, out_ready=1 -> out0=0xFFFE0001 exactly LAT cycles after accept, with m_o equal to the m_i sent.
REQ-036 SHALL verify throughput: W=384, 1000 back-to-back random ops with out_ready=1 -> every product matches the model, in_ready never drops, and out_valid is continuous after the first LAT cycles.
REQ-037 SHALL verify backpressure: out_ready=0 with in_valid held -> exactly D accepts, then in_ready=0; releasing out_ready yields D in-order results, then resumes accepting.
REQ-038 SHALL verify simultaneous accept and pop with the FIFO at D-1 entries -> credits unchanged and no overflow (assertion).
REQ-039 SHALL verify reset: rst pulsed with 3 ops in flight -> out_valid=0 for LAT+2 cycles after reset and credits=D.
REQ-040 SHALL verify the self-check: with ZPRIZE_MUL_RESCHK_EN defined and z1 forced corrupt for one op -> chk_err rises on that FIFO write and stays high until rst.

Source files
------------

// File: rtl/zprize_mul_pkg.sv
// Shared constants and helpers for the streaming Karatsuba multiplier:
// latency formula, FIFO depth legality and half-width sizing.
package zprize_mul_pkg;

  function automatic int lat(input int p);
    return p + 3;
  endfunction

  // The FIFO must at least hold everything the pipeline can have in flight.
  function automatic bit d_legal(input int d, input int p);
    return d >= lat(p);
  endfunction

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Width of a half-operand sum, carry included.
  function automatic int wn(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int ptr_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/zprize_mul_leaf_pipe.sv
// Leaf multiplier: WIDTH x WIDTH product, P register stages, with a
// pass-through sideband that travels in lockstep with the product.
module zprize_mul_leaf_pipe #(
  parameter int WIDTH = 192,
  parameter int P     = 4,
  parameter int PW    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [PW-1:0]        pass_i,
  output logic [2*WIDTH-1:0]   prod,
  output logic [PW-1:0]        pass_o
);

  if (P < 1) begin : g_bad_depth
    $error("zprize_mul_leaf_pipe: P must be at least 1");
  end

  logic [2*WIDTH-1:0] prod_q [P];
  logic [PW-1:0]      pass_q [P];

  always_ff @(posedge clk) begin
    prod_q[0] <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
    for (int i = 1; i < P; i++) prod_q[i] <= prod_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P; i++) pass_q[i] <= '0;
    end else begin
      pass_q[0] <= pass_i;
      for (int i = 1; i < P; i++) pass_q[i] <= pass_q[i-1];
    end
  end

  assign prod   = prod_q[P-1];
  assign pass_o = pass_q[P-1];

endmodule

// File: rtl/zprize_mul_kara_stream.sv
// Streaming one-level Karatsuba multiplier with credit-controlled output FIFO.
// Optional residue (mod 3) self-check compiled in with ZPRIZE_MUL_RESCHK_EN.
module zprize_mul_kara_stream
  import zprize_mul_pkg::*;
#(
  parameter int W = 384,
  parameter int P = 4,
  parameter int M = 32,
  parameter int D = P + 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in0,
  input  logic [W-1:0]   in1,
  input  logic [M-1:0]   m_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out0,
  output logic [M-1:0]   m_o,
  output logic           chk_err
);

  localparam int H  = half_w(W);
  localparam int WN = wn(W);
  localparam int AW = ptr_w(D);
  localparam int CW = $clog2(D + 1);

  if (!d_legal(D, P)) begin : g_bad_fifo_depth
    $error("zprize_mul_kara_stream: D must be at least P+3");
  end
  if (W % 2 != 0) begin : g_bad_width
    $error("zprize_mul_kara_stream: W must be even");
  end

  typedef struct packed {
    logic         v;
    logic [M-1:0] m;
`ifdef ZPRIZE_MUL_RESCHK_EN
    logic [1:0]   ra;
    logic [1:0]   rb;
`endif
  } side_t;

  typedef struct packed {
    logic [M-1:0]   m;
    logic [2*W-1:0] p;
  } entry_t;

`ifdef ZPRIZE_MUL_RESCHK_EN
  // Bit i has weight 2^i mod 3, i.e. 1 for even i and 2 for odd i.
  function automatic logic [1:0] mod3(input logic [2*W-1:0] v);
    int unsigned acc = 0;
    for (int i = 0; i < 2*W; i++) if (v[i]) acc += (i % 2 == 0) ? 1 : 2;
    return 2'(acc % 3);
  endfunction

  function automatic logic [1:0] res_mul(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] t = {2'b00, a} * {2'b00, b};
    return 2'(t % 4'd3);
  endfunction
`endif

  logic accept;
  logic pop;
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Pre-add stage: split operands and form the half sums.
  logic [H-1:0] x0_a, x1_a, y0_a, y1_a;
  logic [H:0]   sx_a, sy_a;
  side_t        sa;

  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; only the valid bits need a known state.
    x0_a  <= in0[H-1:0];
    x1_a  <= in0[W-1:H];
    y0_a  <= in1[H-1:0];
    y1_a  <= in1[W-1:H];
    sx_a  <= {1'b0, in0[H-1:0]} + {1'b0, in0[W-1:H]};
    sy_a  <= {1'b0, in1[H-1:0]} + {1'b0, in1[W-1:H]};
    sa.m  <= m_i;
`ifdef ZPRIZE_MUL_RESCHK_EN
    sa.ra <= mod3((2*W)'(in0));
    sa.rb <= mod3((2*W)'(in1));
`endif
    sa.v  <= rst ? 1'b0 : accept;
  end

  logic [W-1:0]    z0_b, z2_b;
  logic [2*WN-1:0] m1_b;
  side_t           sb;
  logic            v2_b, vm_b;

  zprize_mul_leaf_pipe #(.WIDTH(H), .P(P), .PW($bits(side_t))) u_z0 (
    .clk(clk), .rst(rst), .a(x0_a), .b(y0_a), .pass_i(sa), .prod(z0_b), .pass_o(sb)
  );
  zprize_mul_leaf_pipe #(.WIDTH(H), .P(P), .PW(1)) u_z2 (
    .clk(clk), .rst(rst), .a(x1_a), .b(y1_a), .pass_i(sa.v), .prod(z2_b), .pass_o(v2_b)
  );
  zprize_mul_leaf_pipe #(.WIDTH(WN), .P(P), .PW(1)) u_m1 (
    .clk(clk), .rst(rst), .a(sx_a), .b(sy_a), .pass_i(sa.v), .prod(m1_b), .pass_o(vm_b)
  );

  // Middle term; cannot go negative, W+2 bits hold the full range.
  logic [W-1:0]   z0_c, z2_c;
  logic [W+1:0]   z1_c;
  side_t          sc;
  logic [2*W-1:0] prod_d;
  side_t          sd;

  always_ff @(posedge clk) begin
    z0_c <= z0_b;
    z2_c <= z2_b;
    z1_c <= m1_b - (W+2)'(z2_b) - (W+2)'(z0_b);
    sc   <= sb;
    sc.v <= rst ? 1'b0 : (sb.v & v2_b & vm_b);
  end

  always_ff @(posedge clk) begin
    prod_d <= {z2_c, z0_c} + ((2*W)'(z1_c) << H);
    sd     <= sc;
    sd.v   <= rst ? 1'b0 : sc.v;
  end

  // Output FIFO; credits guarantee a write never lands on a full FIFO.
  entry_t         mem [D];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, credits;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count alone decides what is valid.
    if (sd.v) mem[wr_ptr] <= '{m: sd.m, p: prod_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(D);
    end else begin
      if (sd.v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(sd.v) - CW'(pop);
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign in_ready  = (credits != '0);
  assign out_valid = (count != '0);
  assign out0      = out_valid ? mem[rd_ptr].p : '0;
  assign m_o       = out_valid ? mem[rd_ptr].m : '0;

`ifdef ZPRIZE_MUL_RESCHK_EN
  always_ff @(posedge clk) begin
    if (rst) chk_err <= 1'b0;
    else if (sd.v && (res_mul(sd.ra, sd.rb) != mod3(prod_d))) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_zprize_mul_kara_stream.sv
// Directed bench for zprize_mul_kara_stream: a W=16 instance for the all-ones
// latency case and a W=384 instance for throughput, backpressure and reset.
module tb_zprize_mul_kara_stream;

  localparam int W   = 384;
  localparam int P   = 4;
  localparam int M   = 32;
  localparam int D   = P + 5;
  localparam int LAT = P + 3;
  localparam int SW  = 16;
  localparam int SM  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, chk_err;
  logic [W-1:0]   in0, in1;
  logic [M-1:0]   m_i, m_o;
  logic [2*W-1:0] out0;

  logic            s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_chk_err;
  logic [SW-1:0]   s_in0, s_in1;
  logic [SM-1:0]   s_m_i, s_m_o;
  logic [2*SW-1:0] s_out0;

  zprize_mul_kara_stream #(.W(W), .P(P), .M(M), .D(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .m_i(m_i), .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .m_o(m_o), .chk_err(chk_err)
  );

  zprize_mul_kara_stream #(.W(SW), .P(P), .M(SM), .D(D)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in0(s_in0), .in1(s_in1), .m_i(s_m_i), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out0(s_out0), .m_o(s_m_o), .chk_err(s_chk_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc;
  logic [2*W-1:0] exp_q [$];
  logic [M-1:0]   expm_q [$];
  logic [W-1:0]   a, b;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Drive one operation; the model records it only if this edge accepts it.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [M-1:0] m,
                      output bit acc);
    in_valid = 1'b1;
    in0      = x;
    in1      = y;
    m_i      = m;
    acc      = in_ready;
    if (acc) begin
      exp_q.push_back(mul(x, y));
      expm_q.push_back(m);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [2*W-1:0] e = exp_q.pop_front();
    logic [M-1:0]   em = expm_q.pop_front();
    check({tag, "_hi"}, out0[2*W-1:W], e[2*W-1:W]);
    check({tag, "_lo"}, out0[W-1:0], e[W-1:0]);
    check({tag, "_m"}, m_o, em);
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    in_valid = 1'b0; in0 = '0; in1 = '0; m_i = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in0 = '0; s_in1 = '0; s_m_i = '0; s_out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out0", out0[W-1:0], 0);
    check("rst_m_o", m_o, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_credits", dut.credits, D);
    check("rst_s_out_valid", s_out_valid, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_s_in_ready", s_in_ready, 1);

    // All-ones at W=16: result appears exactly LAT edges after the accept edge.
    s_in0 = 16'hFFFF; s_in1 = 16'hFFFF; s_m_i = 8'hA5;
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    check("ones_in_ready", s_in_ready, 1);
    step();
    s_in_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      check("ones_early", s_out_valid, 0);
      step();
    end
    check("ones_valid", s_out_valid, 1);
    check("ones_out0", s_out0, 32'hFFFE_0001);
    check("ones_m_o", s_m_o, 8'hA5);
    step();
    check("ones_popped", s_out_valid, 0);

    // Full throughput: directed corner operands first, then random.
    out_ready = 1'b1;
    for (int c = 0; c < 1000 + LAT + 3; c++) begin
      check("tp_out_valid", out_valid, (c >= LAT + 1 && c <= LAT + 1000));
      if (out_valid && exp_q.size() != 0) pop_check("tp");
      if (c < 1000) begin
        case (c)
          0:       begin a = '0; b = rnd(); end
          1:       begin a = '1; b = '1; end
          2:       begin a = '1; b = W'(1); end
          3:       begin a = '0; a[W-1] = 1'b1; b = W'(2); end
          default: begin a = rnd(); b = rnd(); end
        endcase
        check("tp_in_ready", in_ready, 1);
        send(a, b, M'($urandom), acc);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    check("tp_drained", exp_q.size(), 0);
    check("tp_chk_err", chk_err, 0);

    // Backpressure: exactly D accepts, held output, then in-order drain.
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < D + LAT + 4; c++) begin
      send(rnd(), rnd(), M'($urandom), acc);
      if (acc) n_acc++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepts", n_acc, D);
    check("bp_in_ready", in_ready, 0);
    check("bp_credits", dut.credits, 0);
    check("bp_hold0_lo", out0[W-1:0], exp_q[0][W-1:0]);
    step();
    check("bp_hold1_lo", out0[W-1:0], exp_q[0][W-1:0]);
    check("bp_hold1_m", m_o, expm_q[0]);
    out_ready = 1'b1;
    for (int c = 0; c < 3 * D; c++) begin
      if (out_valid && exp_q.size() != 0) pop_check("bp");
      step();
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_resume", in_ready, 1);
    check("bp_credits_back", dut.credits, D);

    // Simultaneous accept and pop with D-1 entries queued.
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 2 * D && n_acc < D - 1; c++) begin
      send(rnd(), rnd(), M'($urandom), acc);
      if (acc) n_acc++;
      step();
    end
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    check("sim_count_before", dut.count, D - 1);
    check("sim_credits_before", dut.credits, 1);
    send(rnd(), rnd(), M'($urandom), acc);
    check("sim_accepted", acc, 1);
    out_ready = 1'b1;
    pop_check("sim_pop");
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sim_credits_same", dut.credits, 1);
    repeat (LAT + 2) step();
    check("sim_count_after", dut.count, D - 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3 * D; c++) begin
      if (out_valid && exp_q.size() != 0) pop_check("sim");
      step();
    end
    check("sim_drained", exp_q.size(), 0);
    check("sim_credits_back", dut.credits, D);

    // Reset with three operations in flight discards all of them.
    for (int k = 0; k < 3; k++) begin
      send(rnd(), rnd(), M'($urandom), acc);
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    expm_q.delete();
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_credits", dut.credits, D);
    for (int k = 0; k < LAT + 2; k++) begin
      check("mid_rst_quiet", out_valid, 0);
      step();
    end
    check("mid_rst_chk_err", chk_err, 0);
    check("s_chk_err", s_chk_err, 0);

`ifdef ZPRIZE_MUL_RESCHK_EN
    // Corrupt the middle term of one lone operation; chk_err must latch.
    a = '0;
    a[W/2] = 1'b1;
    a[0] = 1'b1;
    send(a, a, '0, acc);
    step();
    in_valid = 1'b0;
    force dut.z1_c = '0;
    repeat (P + 2) step();
    release dut.z1_c;
    check("chk_before_write", chk_err, 0);
    step();
    check("chk_on_write", chk_err, 1);
    repeat (5) step();
    check("chk_sticky", chk_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("chk_cleared", chk_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
